// File: rtl/logic_serial_ctrl_if.sv
// logic_serial_ctrl_if: request/response bundle between ALU issue logic and the serial controller
interface logic_serial_ctrl_if #(parameter int WIDTH = 8);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_opsel;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_err;
  modport master (
    output req_valid, req_opsel, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err
  );
  modport slave (
    input  req_valid, req_opsel, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err
  );
endinterface

// File: rtl/logic_serial_ctrl.sv
// logic_serial_ctrl: LSB-first bit-serial sequencer for the 1-bit logic slice; LSER_ROTATE_EN turns op 101 into rotate-left
module logic_serial_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_serial_ctrl_if.slave   bus,
  output logic [2:0]           slice_opsel,
  output logic                 slice_op1,
  output logic                 slice_op2,
  output logic                 slice_cin,
  input  logic                 slice_result,
  input  logic                 slice_cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CNT_W-1:0] idx;
  logic carry, cout_q, err_q, legal, last, init_carry, run;
  assign legal = bus.req_opsel inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
  assign last = idx == CNT_W'(WIDTH - 1);
  assign run = state == RUN;
`ifdef LSER_ROTATE_EN
  assign init_carry = bus.req_opsel == 3'b101 ? bus.req_a[WIDTH-1] : bus.req_cin;
`else
  assign init_carry = bus.req_cin;
`endif
  // State register; reset aborts any in-flight operation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state plus handshake and slice drive; the slice only sees an opcode while running
  always_comb begin
    state_nx = state == IDLE ? (bus.req_valid ? (legal ? RUN : DONE) : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (bus.rsp_ready ? IDLE : DONE);
    bus.req_ready  = state == IDLE;
    bus.rsp_valid  = state == DONE;
    bus.rsp_result = res_q;
    bus.rsp_cout   = cout_q;
    bus.rsp_err    = err_q;
    slice_opsel    = run ? op_q : 3'b000;
    slice_op1      = run && a_q[idx];
    slice_op2      = run && b_q[idx];
    slice_cin      = run && carry;
  end
  // Operand latch at accept, then one result bit and carry captured per RUN cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state == IDLE && bus.req_valid) begin
      op_q   <= bus.req_opsel;
      a_q    <= bus.req_a;
      b_q    <= bus.req_b;
      res_q  <= '0;
      idx    <= '0;
      carry  <= init_carry;
      cout_q <= 1'b0;
      err_q  <= !legal;
    end else if (run) begin
      res_q[idx] <= slice_result;
      carry      <= slice_cout;
      idx        <= last ? idx : idx + 1'b1;
      cout_q     <= last ? slice_cout : cout_q;
    end else if (state == DONE && bus.rsp_ready) begin
      err_q <= 1'b0;
    end
endmodule
